fex7_to_bin: RTL and testbench
==============================

# fex7_to_bin

Sequential decoder from 7-digit factorial-base (factoradic) form to a plain binary integer. It is the consumer-side counterpart of the factoradic incrementer: a producer hands over a digit vector, and this block returns value = f1·1! + f2·2! + … + f7·7! in the range 0..40319. It evaluates the value by Horner iteration, one digit per cycle, behind valid/ready handshakes on both sides.

## Interface
Parameters: none. Widths are fixed by package constants.

- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: asynchronous assert, active-low reset.
- `in_valid` in 1: digit vector offered.
- `in_ready` out 1: block can accept; high only in IDLE.
- `in_f1` in 1: digit 1, legal range 0..1.
- `in_f2` in 2: digit 2, legal range 0..2.
- `in_f3` in 2: digit 3, legal range 0..3.
- `in_f4` in 3: digit 4, legal range 0..4.
- `in_f5` in 3: digit 5, legal range 0..5.
- `in_f6` in 3: digit 6, legal range 0..6.
- `in_f7` in 3: digit 7, legal range 0..7.
- `out_valid` out 1: result available.
- `out_ready` in 1: consumer takes result.
- `out_value` out 16: decoded integer.
- `out_err` out 1: illegal digit seen (see Configuration).

## Operation
- States: IDLE, RUN, DONE.
- **IDLE**
  - `in_ready` = 1.
  - On `in_valid` & `in_ready`, all seven digits are latched into internal registers.
  - The accumulator is loaded with `acc` = f7 and the step multiplier with k = 7.
  - Next state is RUN.
  - Inputs are don't-care after the accept edge.
- **RUN**, one step per cycle:
  - `acc` ← `acc`·k + f(k−1), then k ← k−1.
  - After the step with k = 2 (which adds f1), next state is DONE. RUN is therefore exactly 6 cycles.
- **DONE**
  - `out_valid` = 1; `out_value` and `out_err` hold stable.
  - On `out_ready`, next state is IDLE.
- Arithmetic:
  - The accumulator is 16 bits unsigned; no truncation is needed.
  - Worst case with every field at its bit-width maximum is 41353, which is < 2^16.
  - Multiply-by-k (k = 2..7) is built from shifts and adds; no generic multiplier.
- Outputs are registered. In IDLE and RUN, `out_value` holds the last result (0 after reset).
- Reset values: `in_ready` = 0 while `rst_n` is low, then 1 in IDLE; `out_valid` = 0, `out_value` = 0, `out_err` = 0, state = IDLE, k = 7.
- Reset mid-operation: the computation is abandoned immediately, with no output pulse. After release the block is in IDLE with all outputs at their reset values.
- `in_valid` in RUN or DONE is ignored (`in_ready` = 0). The producer must hold the vector stable until accepted.

## Timing
- Accept at edge N.
- `out_valid` rises after edge N+7, i.e. 7 cycles of latency.
- Earliest next accept is at edge N+9, giving a minimum initiation interval of 9 cycles with `out_ready` held at 1.
- `out_valid` high and `out_ready` high at the same edge means DONE→IDLE; `in_ready` rises the following cycle.
- Backpressure: DONE is held indefinitely, with no timeout.

## Configuration
- `FEX_RANGE_CHECK_EN`
  - **Defined:** at accept, each digit is compared against its legal maximum (f2 > 2, f4 > 4, f5 > 5, f6 > 6). If any comparison fails, an error flag is set and presented as `out_err` = 1 with the result in DONE. The value is still computed arithmetically from the raw digits.
  - **Undefined:** `out_err` is tied to 0, no comparators are synthesized, and illegal digits are decoded arithmetically without indication.

## Structure
- `fex_pkg` holds:
  - `FEX_DIGITS` = 7
  - `FEX_VAL_W` = 16
  - `FEX_MAX` = 40319
  - per-digit width constants
  - the state enum `fex_dec_state_t` (IDLE, RUN, DONE)
- One sub-module, `fex_mac_small`: combinational `acc`·k + d, with k in 2..7 and d 3 bits, producing 16 bits. It is reusable by a future binary-to-factoradic encoder.

## Test plan
- All digits 0 → `out_value` = 0, `out_err` = 0, `out_valid` exactly 7 cycles after accept.
- f1=1, f2=2, f3=3, f4=4, f5=5, f6=6, f7=7 → 40319. Separately, f7=1 with others 0 → 5040, and f2=1, f3=1 with others 0 → 8.
- Sweep: drive the incrementer from 0 for 40320 steps and feed each state in turn → `out_value` equals the step count, wrapping to 0 at step 40320.
- `out_ready` held low for 5 cycles in DONE → `out_value`, `out_valid` stable, `in_ready` = 0 throughout. A new `in_valid` during this window is not accepted.
- f2=3, others 0:
  - with `FEX_RANGE_CHECK_EN` → `out_value` = 6, `out_err` = 1;
  - without it → `out_value` = 6, `out_err` = 0.
- `rst_n` pulsed low in the 3rd RUN cycle → all outputs 0 immediately, no `out_valid`. A following accept of f1=1 yields 1.

Source files
------------

// File: rtl/fex7_to_bin_pkg.sv
// Shared constants and state encoding for the factoradic decoder family.
// Combinational definitions only; no latency.
// No handshake; consumed by the decoder, its MAC and its interface.
package fex_pkg;

  localparam int FEX_DIGITS = 7;
  localparam int FEX_VAL_W  = 16;
  localparam int FEX_MAX    = 40319;
  localparam int FEX_K_W    = 3;

  localparam int FEX_F1_W = 1;
  localparam int FEX_F2_W = 2;
  localparam int FEX_F3_W = 2;
  localparam int FEX_F4_W = 3;
  localparam int FEX_F5_W = 3;
  localparam int FEX_F6_W = 3;
  localparam int FEX_F7_W = 3;

  typedef enum logic [1:0] {
    FEX_IDLE = 2'd0,
    FEX_RUN  = 2'd1,
    FEX_DONE = 2'd2
  } fex_dec_state_t;

endpackage

// File: rtl/fex7_to_bin_if.sv
// Digit-vector input and binary-result output handshakes of fex7_to_bin.
// Wires only; no latency.
// valid/ready on both sides; slave is the decoder, master is the producer/consumer.
interface fex7_to_bin_if;
  import fex_pkg::*;

  logic                 in_valid;
  logic                 in_ready;
  logic [FEX_F1_W-1:0]  in_f1;
  logic [FEX_F2_W-1:0]  in_f2;
  logic [FEX_F3_W-1:0]  in_f3;
  logic [FEX_F4_W-1:0]  in_f4;
  logic [FEX_F5_W-1:0]  in_f5;
  logic [FEX_F6_W-1:0]  in_f6;
  logic [FEX_F7_W-1:0]  in_f7;
  logic                 out_valid;
  logic                 out_ready;
  logic [FEX_VAL_W-1:0] out_value;
  logic                 out_err;

  modport slave (
    input  in_valid, in_f1, in_f2, in_f3, in_f4, in_f5, in_f6, in_f7, out_ready,
    output in_ready, out_valid, out_value, out_err
  );

  modport master (
    output in_valid, in_f1, in_f2, in_f3, in_f4, in_f5, in_f6, in_f7, out_ready,
    input  in_ready, out_valid, out_value, out_err
  );

endinterface

// File: rtl/fex7_to_bin_mac_small.sv
// Combinational acc*k + d for k in 2..7, built from shifts and adds.
// Zero latency; no handshake, result valid whenever inputs are.
module fex_mac_small
  import fex_pkg::*;
(
  input  logic [FEX_VAL_W-1:0] acc,
  input  logic [FEX_K_W-1:0]   k,
  input  logic [2:0]           d,
  output logic [FEX_VAL_W-1:0] res
);

  logic [FEX_VAL_W-1:0] prod;

  // The x7 case relies on modulo-2^16 wrap of acc<<3; the true product fits.
  always_comb begin
    case (k)
      3'd2:    prod = acc << 1;
      3'd3:    prod = (acc << 1) + acc;
      3'd4:    prod = acc << 2;
      3'd5:    prod = (acc << 2) + acc;
      3'd6:    prod = (acc << 2) + (acc << 1);
      3'd7:    prod = (acc << 3) - acc;
      default: prod = acc;
    endcase
    res = prod + FEX_VAL_W'(d);
  end

endmodule

// File: rtl/fex7_to_bin.sv
// Horner decoder of 7-digit factoradic to binary; FEX_RANGE_CHECK_EN adds illegal-digit flag.
// Latency: out_valid 7 cycles after accept; minimum initiation interval 9.
// in_ready only in IDLE; result held in DONE until out_ready, no timeout.
module fex7_to_bin
  import fex_pkg::*;
(
  input logic          clk,
  input logic          rst_n,
  fex7_to_bin_if.slave bus
);

  localparam logic [1:0]         S_IDLE = FEX_IDLE;
  localparam logic [1:0]         S_RUN  = FEX_RUN;
  localparam logic [1:0]         S_DONE = FEX_DONE;
  localparam logic [FEX_K_W-1:0] K_INIT = FEX_K_W'(FEX_DIGITS);

  logic [1:0]           state_q, state_d;
  logic [FEX_K_W-1:0]   k_q, k_d;
  logic [FEX_VAL_W-1:0] acc_q, acc_d;
  logic [5:0][2:0]      dig_q, dig_d;
  logic                 err_q, err_d;
  logic                 out_valid_q, out_valid_d;
  logic [FEX_VAL_W-1:0] out_value_q, out_value_d;
  logic                 out_err_q, out_err_d;
  logic [FEX_VAL_W-1:0] mac_res;
  logic [2:0]           step_dig;
  logic                 in_err;

`ifdef FEX_RANGE_CHECK_EN
  // f1, f3 and f7 cannot exceed their maximum within their port widths.
  assign in_err = (bus.in_f2 > 2'd2) || (bus.in_f4 > 3'd4) ||
                  (bus.in_f5 > 3'd5) || (bus.in_f6 > 3'd6);
`else
  assign in_err = 1'b0;
`endif

  // dig_q[i] holds digit f(i+1); step k consumes f(k-1).
  always_comb begin
    case (k_q)
      3'd7:    step_dig = dig_q[5];
      3'd6:    step_dig = dig_q[4];
      3'd5:    step_dig = dig_q[3];
      3'd4:    step_dig = dig_q[2];
      3'd3:    step_dig = dig_q[1];
      3'd2:    step_dig = dig_q[0];
      default: step_dig = 3'd0;
    endcase
  end

  fex_mac_small u_mac (
    .acc (acc_q),
    .k   (k_q),
    .d   (step_dig),
    .res (mac_res)
  );

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    acc_d       = acc_q;
    dig_d       = dig_q;
    err_d       = err_q;
    out_valid_d = out_valid_q;
    out_value_d = out_value_q;
    out_err_d   = out_err_q;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          dig_d = {3'(bus.in_f6), 3'(bus.in_f5), 3'(bus.in_f4),
                   3'(bus.in_f3), 3'(bus.in_f2), 3'(bus.in_f1)};
          acc_d   = FEX_VAL_W'(bus.in_f7);
          k_d     = K_INIT;
          err_d   = in_err;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        acc_d = mac_res;
        k_d   = k_q - 3'd1;
        if (k_q == 3'd2) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        // First DONE cycle loads the output registers; the handshake follows.
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
          out_value_d = acc_q;
          out_err_d   = err_q;
        end else if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      k_q         <= K_INIT;
      acc_q       <= '0;
      dig_q       <= '0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_value_q <= '0;
      out_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      acc_q       <= acc_d;
      dig_q       <= dig_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
      out_value_q <= out_value_d;
      out_err_q   <= out_err_d;
    end
  end

  assign bus.in_ready  = rst_n && (state_q == S_IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.out_value = out_value_q;
  assign bus.out_err   = out_err_q;

endmodule

// File: tb/tb_fex7_to_bin.sv
// Self-checking bench for fex7_to_bin: vector table, hand sequences, random digits.
// Reference values come from the factorial-weighted digit sum.
module tb_fex7_to_bin;
  import fex_pkg::*;

`ifdef FEX_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fex7_to_bin_if bus ();

  fex7_to_bin dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [20:0] d;
    logic [16:0] val;
    logic        err;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [20:0] mk(input int f1, input int f2, input int f3, input int f4,
                                     input int f5, input int f6, input int f7);
    return {3'(f7), 3'(f6), 3'(f5), 3'(f4), 3'(f3), 3'(f2), 3'(f1)};
  endfunction

  function automatic int model_val(input logic [20:0] d);
    int v = 0;
    int fact = 1;
    for (int i = 1; i <= 7; i++) begin
      fact = fact * i;
      v = v + int'(d[3*(i-1) +: 3]) * fact;
    end
    return v;
  endfunction

  function automatic bit model_err(input logic [20:0] d);
    if (!RC) return 1'b0;
    return (d[5:3] > 3'd2) || (d[11:9] > 3'd4) || (d[14:12] > 3'd5) || (d[17:15] > 3'd6);
  endfunction

  task automatic drive(input logic [20:0] d);
    bus.in_f1 = d[0];
    bus.in_f2 = d[4:3];
    bus.in_f3 = d[7:6];
    bus.in_f4 = d[11:9];
    bus.in_f5 = d[14:12];
    bus.in_f6 = d[17:15];
    bus.in_f7 = d[20:18];
  endtask

  task automatic accept(input logic [20:0] d, output bit ok);
    ok = 1'b0;
    @(negedge clk);
    drive(d);
    bus.in_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (bus.in_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      chk("accept_timeout", 0, 1);
      bus.in_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
    end
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("idle_timeout", 0, 1);
  endtask

  task automatic run_vec(input logic [20:0] d, input int exp_v, input bit exp_e, input string tag);
    bit ok;
    int lat;
    accept(d, ok);
    if (ok) begin
      wait_out(lat);
      chk({tag, "_lat"}, lat, 7);
      chk({tag, "_val"}, int'(bus.out_value), exp_v);
      chk({tag, "_err"}, int'(bus.out_err), int'(exp_e));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int lat;
    int acc_at [$];
    int hi_cnt;
    int n;
    int r;
    logic [20:0] d;

    tbl[0] = '{d: mk(0, 0, 0, 0, 0, 0, 0), val: 17'd0,     err: 1'b0};
    tbl[1] = '{d: mk(1, 2, 3, 4, 5, 6, 7), val: 17'd40319, err: 1'b0};
    tbl[2] = '{d: mk(0, 0, 0, 0, 0, 0, 1), val: 17'd5040,  err: 1'b0};
    tbl[3] = '{d: mk(0, 1, 1, 0, 0, 0, 0), val: 17'd8,     err: 1'b0};
    tbl[4] = '{d: mk(0, 3, 0, 0, 0, 0, 0), val: 17'd6,     err: RC};
    tbl[5] = '{d: mk(1, 0, 0, 0, 0, 0, 0), val: 17'd1,     err: 1'b0};
    tbl[6] = '{d: mk(1, 3, 3, 7, 7, 7, 7), val: 17'd41353, err: RC};
    tbl[7] = '{d: mk(0, 0, 0, 0, 0, 6, 0), val: 17'd4320,  err: 1'b0};

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    drive('0);

    repeat (3) @(negedge clk);
    chk("rst_in_ready", int'(bus.in_ready), 0);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_out_value", int'(bus.out_value), 0);
    chk("rst_out_err", int'(bus.out_err), 0);
    rst_n = 1'b1;
    #1 chk("post_rst_in_ready", int'(bus.in_ready), 1);

    for (int i = 0; i < 8; i++) begin
      run_vec(tbl[i].d, int'(tbl[i].val), tbl[i].err, $sformatf("tbl%0d", i));
    end

    // Back-to-back accepts with in_valid and out_ready held high.
    @(negedge clk);
    drive(mk(1, 1, 0, 0, 0, 0, 0));
    bus.in_valid = 1'b1;
    for (int c = 0; c < 30; c++) begin
      if (bus.in_ready) acc_at.push_back(c);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    chk("ii_accepts", acc_at.size(), 4);
    if (acc_at.size() >= 2) chk("ii_interval", acc_at[1] - acc_at[0], 9);
    chk("ii_last_val", int'(bus.out_value), 3);
    wait_idle();

    // Backpressure: DONE held for 5 cycles while a new vector is offered.
    bus.out_ready = 1'b0;
    accept(mk(1, 0, 0, 0, 0, 0, 1), ok);
    wait_out(lat);
    chk("bp_lat", lat, 7);
    chk("bp_val", int'(bus.out_value), 5041);
    drive(mk(0, 2, 0, 0, 0, 0, 2));
    bus.in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("bp_hold_valid%0d", c), int'(bus.out_valid), 1);
      chk($sformatf("bp_hold_value%0d", c), int'(bus.out_value), 5041);
      chk($sformatf("bp_hold_in_ready%0d", c), int'(bus.in_ready), 0);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_valid", int'(bus.out_valid), 0);
    chk("bp_release_in_ready", int'(bus.in_ready), 1);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    wait_out(lat);
    chk("bp_next_lat", lat, 7);
    chk("bp_next_val", int'(bus.out_value), model_val(mk(0, 2, 0, 0, 0, 0, 2)));

    // Reset asserted in the third RUN cycle.
    accept(mk(1, 1, 1, 1, 1, 1, 1), ok);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", int'(bus.out_valid), 0);
    chk("mid_rst_out_value", int'(bus.out_value), 0);
    chk("mid_rst_out_err", int'(bus.out_err), 0);
    chk("mid_rst_in_ready", int'(bus.in_ready), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("mid_rst_release_in_ready", int'(bus.in_ready), 1);
    hi_cnt = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (bus.out_valid) hi_cnt++;
    end
    chk("mid_rst_no_pulse", hi_cnt, 0);
    run_vec(mk(1, 0, 0, 0, 0, 0, 0), 1, 1'b0, "mid_rst_after");

    // Random digits over the full port widths, including illegal values.
    for (int i = 0; i < 250; i++) begin
      d = mk($urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 3),
             $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
             $urandom_range(0, 7));
      run_vec(d, model_val(d), model_err(d), $sformatf("rnd%0d", i));
    end

    // Counter-style sweep points: digits from the factoradic form of n.
    for (int i = 0; i < 80; i++) begin
      if (i == 0)      n = FEX_MAX;
      else if (i == 1) n = FEX_MAX + 1;
      else if (i == 2) n = 0;
      else             n = $urandom_range(0, FEX_MAX + 1);
      r = n % (FEX_MAX + 1);
      d = '0;
      for (int j = 1; j <= 7; j++) begin
        d[3*(j-1) +: 3] = 3'(r % (j + 1));
        r = r / (j + 1);
      end
      run_vec(d, n % (FEX_MAX + 1), 1'b0, $sformatf("sweep%0d", n));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
